// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 keyboard receiver and event decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_REL   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int KEY_TGL = 10;
  localparam int KEY_PRS = 9;
  localparam int KEY_EXT = 8;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Keyboard status/ack bytes that never carry a key event.
  function automatic logic is_discard(input logic [7:0] code);
    logic hit;
    case (code)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: hit = 1'b1;
      default:                                  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host line conditioning and 11-bit frame deserialiser with
// an inter-edge timeout that abandons stalled frames.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 48000000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 2000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_stb,
  output logic [7:0] byte_dat,
  output logic       frame_err,
  output logic       timeout
);

  localparam int TO_LIMIT = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [1:0] line_raw;
  logic [1:0] filt_level;
  logic [1:0] filt_low;

  assign line_raw = {ps2_data, ps2_clk};

  // Index 0 is the clock line, index 1 the data line.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic [1:0]            sync_reg;
      logic [FILTER_LEN-1:0] shift_reg;
      logic                  level_reg;

      always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg  <= '1;
          shift_reg <= '1;
          level_reg <= 1'b1;
        end else begin
          sync_reg  <= {sync_reg[0], line_raw[gi]};
          shift_reg <= {shift_reg[FILTER_LEN-2:0], sync_reg[1]};
          if (&shift_reg)
            level_reg <= 1'b1;
          else if (~|shift_reg)
            level_reg <= 1'b0;
        end
      end

      assign filt_level[gi] = level_reg;
      assign filt_low[gi]   = ~|shift_reg;
    end
  endgenerate

  // The filtered clock is about to drop: one strobe per falling edge.
  logic sample_stb;
  logic din;
  assign sample_stb = filt_level[0] & filt_low[0];
  assign din        = filt_level[1];

  rx_state_t        state_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             parity_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic             byte_stb_reg;
  logic [7:0]       byte_dat_reg;
  logic             frame_err_reg;
  logic             timeout_reg;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RX_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      to_cnt_reg    <= '0;
      byte_stb_reg  <= 1'b0;
      byte_dat_reg  <= '0;
      frame_err_reg <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      byte_stb_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      if (sample_stb) begin
        to_cnt_reg <= '0;
        case (state_reg)
          RX_IDLE: begin
            if (!din) begin
              state_reg   <= RX_DATA;
              bit_cnt_reg <= '0;
            end
          end
          RX_DATA: begin
            shift_reg   <= {din, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7)
              state_reg <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_reg <= din;
            state_reg  <= RX_STOP;
          end
          RX_STOP: begin
            if (din && ^{parity_reg, shift_reg}) begin
              byte_stb_reg <= 1'b1;
              byte_dat_reg <= shift_reg;
            end else begin
              frame_err_reg <= 1'b1;
            end
            state_reg <= RX_IDLE;
          end
          default: state_reg <= RX_IDLE;
        endcase
      end else if (state_reg == RX_IDLE) begin
        to_cnt_reg <= '0;
      end else if (to_cnt_reg == TO_W'(TO_LIMIT)) begin
        frame_err_reg <= 1'b1;
        timeout_reg   <= 1'b1;
        state_reg     <= RX_IDLE;
        to_cnt_reg    <= '0;
      end else begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
    end
  end

  assign byte_stb  = byte_stb_reg;
  assign byte_dat  = byte_dat_reg;
  assign frame_err = frame_err_reg;
  assign timeout   = timeout_reg;

endmodule

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard front end: folds E0/F0/E1 prefixes into single toggle-flagged
// key events on ps2_key for the core's keyboard decoder.
module ps2_key_gen
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 48000000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 2000
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        byte_stb,
  output logic [7:0]  byte_dat,
  output logic        frame_err
);

  logic       rx_stb;
  logic [7:0] rx_dat;
  logic       rx_err;
  logic       rx_timeout;

  ps2_frame_rx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_US (TIMEOUT_US)
  ) u_frame_rx (
    .clk_sys  (clk_sys),
    .rst_n    (RESET_N),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byte_stb (rx_stb),
    .byte_dat (rx_dat),
    .frame_err(rx_err),
    .timeout  (rx_timeout)
  );

  logic [10:0] key_reg;
  logic        ext_reg;
  logic        rel_reg;
  logic [2:0]  skip_reg;

  // A stalled frame loses sync with the prefix stream, so partial prefixes are dropped.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      key_reg  <= '0;
      ext_reg  <= 1'b0;
      rel_reg  <= 1'b0;
      skip_reg <= '0;
    end else if (rx_timeout) begin
      ext_reg  <= 1'b0;
      rel_reg  <= 1'b0;
      skip_reg <= '0;
    end else if (rx_stb) begin
      if (skip_reg != 3'd0) begin
        skip_reg <= skip_reg - 3'd1;
      end else if (rx_dat == PS2_PAUSE) begin
        skip_reg <= PAUSE_SKIP;
      end else if (rx_dat == PS2_EXT) begin
        ext_reg <= 1'b1;
      end else if (rx_dat == PS2_REL) begin
        rel_reg <= 1'b1;
      end else if (!is_discard(rx_dat)) begin
        key_reg[KEY_TGL] <= ~key_reg[KEY_TGL];
        key_reg[KEY_PRS] <= ~rel_reg;
        key_reg[KEY_EXT] <= ext_reg;
        key_reg[7:0]     <= rx_dat;
        ext_reg          <= 1'b0;
        rel_reg          <= 1'b0;
      end
    end
  end

  assign ps2_key   = key_reg;
  assign byte_stb  = rx_stb;
  assign byte_dat  = rx_dat;
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_gen.sv
// Directed bench for ps2_key_gen: scripted PS/2 frames, a queue-based event model
// checked every cycle, plus literal key values at checkpoints.
`timescale 1ns/1ps
module tb_ps2_key_gen;

  logic        clk_sys = 1'b0;
  logic        RESET_N;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        byte_stb;
  logic [7:0]  byte_dat;
  logic        frame_err;

  always #5 clk_sys = ~clk_sys;

  ps2_key_gen #(
    .CLK_FREQ_HZ(1000000),
    .FILTER_LEN (8),
    .TIMEOUT_US (2000)
  ) dut (
    .clk_sys  (clk_sys),
    .RESET_N  (RESET_N),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .byte_stb (byte_stb),
    .byte_dat (byte_dat),
    .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model of the event stream, driven by the bytes the bench sends.
  logic [7:0]  exp_bytes[$];
  logic [10:0] exp_keys[$];
  int          exp_err = 0;
  bit          m_tgl = 0, m_ext = 0, m_rel = 0;
  int          m_skip = 0;
  int          n_stb = 0, n_err = 0;

  task automatic model_byte(input logic [7:0] b);
    exp_bytes.push_back(b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_rel = 1;
    else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) ;
    else begin
      m_tgl = !m_tgl;
      exp_keys.push_back({m_tgl, !m_rel, m_ext, b});
      m_ext = 0;
      m_rel = 0;
    end
  endtask

  // Per-cycle compare process.
  logic [10:0] prev_key = '0;
  logic        stb_d = 0, err_d = 0;
  always @(negedge clk_sys) begin
    if (!RESET_N) begin
      prev_key = '0;
      stb_d    = 0;
      err_d    = 0;
    end else begin
      if (byte_stb) begin
        n_stb++;
        chk("stb_pulse_width", {31'd0, stb_d}, 32'd0);
        if (exp_bytes.size() == 0) chk("unexpected_byte_stb", {24'd0, byte_dat}, 32'hFFFF_FFFF);
        else chk("byte_dat", {24'd0, byte_dat}, {24'd0, exp_bytes.pop_front()});
      end
      if (frame_err) begin
        n_err++;
        chk("err_pulse_width", {31'd0, err_d}, 32'd0);
        chk("unexpected_frame_err", {31'd0, (exp_err > 0)}, 32'd1);
        if (exp_err > 0) exp_err--;
      end
      if (ps2_key !== prev_key) begin
        chk("key_latency_after_stb", {31'd0, stb_d}, 32'd1);
        if (exp_keys.size() == 0) chk("unexpected_key_event", {21'd0, ps2_key}, {21'd0, prev_key});
        else chk("ps2_key_event", {21'd0, ps2_key}, {21'd0, exp_keys.pop_front()});
      end
      prev_key = ps2_key;
      stb_d    = byte_stb;
      err_d    = frame_err;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(30);
    ps2_clk = 1'b0;
    wait_cyc(30);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good);
    logic [10:0] bits;
    if (good) model_byte(b);
    else exp_err++;
    bits = {1'b1, (~^b) ^ !good, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    wait_cyc(150);
  endtask

  task automatic checkpoint(input string name, input logic [10:0] key_lit);
    chk({name, "_key"}, {21'd0, ps2_key}, {21'd0, key_lit});
    chk({name, "_pending_bytes"}, exp_bytes.size(), 0);
    chk({name, "_pending_keys"}, exp_keys.size(), 0);
    chk({name, "_pending_errs"}, exp_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stb0, err0;
    logic [10:0] key0;
    RESET_N  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("reset_key", {21'd0, ps2_key}, 32'd0);
    chk("reset_stb", {31'd0, byte_stb}, 32'd0);
    chk("reset_dat", {24'd0, byte_dat}, 32'd0);
    chk("reset_err", {31'd0, frame_err}, 32'd0);
    RESET_N = 1'b1;
    wait_cyc(20);

    send_frame(8'h1C, 1);
    checkpoint("make_1c", 11'h61C);

    send_frame(8'hF0, 1);
    send_frame(8'h1C, 1);
    checkpoint("break_1c", 11'h01C);

    send_frame(8'hE0, 1);
    send_frame(8'h75, 1);
    checkpoint("ext_make_75", 11'h775);
    send_frame(8'hE0, 1);
    send_frame(8'hF0, 1);
    send_frame(8'h75, 1);
    checkpoint("ext_break_75", 11'h175);
    send_frame(8'h1C, 1);
    checkpoint("ext_cleared", 11'h61C);

    err0 = n_err;
    send_frame(8'hF0, 1);
    send_frame(8'h1C, 0);
    chk("parity_err_count", n_err - err0, 1);
    send_frame(8'h1C, 1);
    checkpoint("after_parity_err", 11'h01C);

    // Stall after the 4th data bit; the timeout must also drop the pending E0.
    send_frame(8'hE0, 1);
    err0 = n_err;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0] ? 1'b0 : 1'b0);
    ps2_data = 1'b1;
    exp_err++;
    m_ext = 0; m_rel = 0; m_skip = 0;
    wait_cyc(2500);
    chk("timeout_err_count", n_err - err0, 1);
    send_frame(8'h1C, 1);
    checkpoint("after_timeout", 11'h61C);

    begin
      logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1);
      checkpoint("pause_swallowed", 11'h61C);
    end
    send_frame(8'h29, 1);
    checkpoint("after_pause", 11'h229);

    send_frame(8'hE0, 1);
    send_frame(8'hAA, 1);
    send_frame(8'h14, 1);
    checkpoint("discard_keeps_ext", 11'h714);

    stb0 = n_stb; err0 = n_err; key0 = ps2_key;
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    wait_cyc(30);
    chk("glitch_no_stb", n_stb - stb0, 0);
    chk("glitch_no_err", n_err - err0, 0);
    chk("glitch_key_hold", {21'd0, ps2_key}, {21'd0, key0});

    // Asynchronous reset in the middle of a frame.
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(posedge clk_sys);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("midreset_key", {21'd0, ps2_key}, 32'd0);
    chk("midreset_stb", {31'd0, byte_stb}, 32'd0);
    chk("midreset_dat", {24'd0, byte_dat}, 32'd0);
    chk("midreset_err", {31'd0, frame_err}, 32'd0);
    ps2_data = 1'b1;
    m_tgl = 0; m_ext = 0; m_rel = 0; m_skip = 0;
    repeat (3) @(negedge clk_sys);
    RESET_N = 1'b1;
    wait_cyc(20);
    send_frame(8'h1C, 1);
    checkpoint("after_midreset", 11'h61C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
